// File: rtl/time_of_day_counter_if.sv
// Time-load request bus: requester drives set_valid/set_h/set_m/set_s,
// the counter answers with set_ready and a one-cycle set_err.
interface time_of_day_counter_if;
  logic       set_valid;
  logic [5:0] set_h;
  logic [6:0] set_m;
  logic [6:0] set_s;
  logic       set_ready;
  logic       set_err;

  modport master (output set_valid, set_h, set_m, set_s, input set_ready, set_err);
  modport slave  (input set_valid, set_h, set_m, set_s, output set_ready, set_err);
endinterface

// File: rtl/time_of_day_counter.sv
// BCD time-of-day counter with prescaler, 12/24-hour display and a one-cycle load FSM.
// Optional alarm comparator enabled by defining TOD_ALARM_EN.
module time_of_day_counter #(
  parameter int DIV   = 50000000,
  parameter int DIV_W = 26
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic                       mode24,
  time_of_day_counter_if.slave       sbus,
`ifdef TOD_ALARM_EN
  input  logic                       alm_we,
  input  logic [5:0]                 alm_h,
  input  logic [6:0]                 alm_m,
  output logic                       alm_hit,
`endif
  output logic [1:0]                 qh1,
  output logic [3:0]                 qh0,
  output logic [2:0]                 qm1,
  output logic [3:0]                 qm0,
  output logic [2:0]                 qs1,
  output logic [3:0]                 qs0,
  output logic                       qpm,
  output logic                       sec_tick,
  output logic                       roll
);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [DIV_W-1:0] presc_reg;
  logic [1:0]       h1_reg;
  logic [3:0]       h0_reg, m0_reg, s0_reg;
  logic [2:0]       m1_reg, s1_reg;
  logic [5:0]       ld_h_reg;
  logic [6:0]       ld_m_reg, ld_s_reg;
  logic             set_err_reg, sec_tick_reg, roll_reg;

  logic [1:0]       inc_h1;
  logic [3:0]       inc_h0, inc_m0, inc_s0;
  logic [2:0]       inc_m1, inc_s1;
  logic             day_wrap, presc_max, set_legal, accept, advance;
  logic [4:0]       hour_bin, hour_12;

  function automatic logic hour_ok(input logic [5:0] h);
    return (h[3:0] <= 4'd9) && ((h[5:4] < 2'd2) || (h[5:4] == 2'd2 && h[3:0] <= 4'd3));
  endfunction

  function automatic logic min_sec_ok(input logic [6:0] v);
    return (v[3:0] <= 4'd9) && (v[6:4] <= 3'd5);
  endfunction

  assign set_legal = hour_ok(sbus.set_h) && min_sec_ok(sbus.set_m) && min_sec_ok(sbus.set_s);
  assign accept    = (state_reg == RUN) && sbus.set_valid && set_legal;
  assign presc_max = (presc_reg == DIV_W'(DIV - 1));
  // An accepted request swallows a coinciding advance: the loaded value wins.
  assign advance   = (state_reg == RUN) && en && presc_max && !accept;
  assign day_wrap  = (h1_reg == 2'd2) && (h0_reg == 4'd3) && (m1_reg == 3'd5) &&
                     (m0_reg == 4'd9) && (s1_reg == 3'd5) && (s0_reg == 4'd9);

  // Ripple-carry BCD increment of the whole time by one second.
  always_comb begin
    inc_h1 = h1_reg;
    inc_h0 = h0_reg;
    inc_m1 = m1_reg;
    inc_m0 = m0_reg;
    inc_s1 = s1_reg;
    inc_s0 = s0_reg + 4'd1;
    if (s0_reg == 4'd9) begin
      inc_s0 = 4'd0;
      inc_s1 = s1_reg + 3'd1;
      if (s1_reg == 3'd5) begin
        inc_s1 = 3'd0;
        inc_m0 = m0_reg + 4'd1;
        if (m0_reg == 4'd9) begin
          inc_m0 = 4'd0;
          inc_m1 = m1_reg + 3'd1;
          if (m1_reg == 3'd5) begin
            inc_m1 = 3'd0;
            if (h1_reg == 2'd2 && h0_reg == 4'd3) begin
              inc_h1 = 2'd0;
              inc_h0 = 4'd0;
            end else if (h0_reg == 4'd9) begin
              inc_h1 = h1_reg + 2'd1;
              inc_h0 = 4'd0;
            end else begin
              inc_h0 = h0_reg + 4'd1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_reg <= RUN;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (accept) state_next = LOAD;
      LOAD:    state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    sbus.set_ready = (state_reg == RUN);
    sbus.set_err   = set_err_reg;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc_reg    <= '0;
      h1_reg       <= '0;
      h0_reg       <= '0;
      m1_reg       <= '0;
      m0_reg       <= '0;
      s1_reg       <= '0;
      s0_reg       <= '0;
      ld_h_reg     <= '0;
      ld_m_reg     <= '0;
      ld_s_reg     <= '0;
      set_err_reg  <= 1'b0;
      sec_tick_reg <= 1'b0;
      roll_reg     <= 1'b0;
    end else begin
      set_err_reg  <= (state_reg == RUN) && sbus.set_valid && !set_legal;
      sec_tick_reg <= advance;
      roll_reg     <= advance && day_wrap;
      if (state_reg == LOAD) begin
        {h1_reg, h0_reg} <= ld_h_reg;
        {m1_reg, m0_reg} <= ld_m_reg;
        {s1_reg, s0_reg} <= ld_s_reg;
        presc_reg        <= '0;
      end else begin
        if (accept) begin
          ld_h_reg <= sbus.set_h;
          ld_m_reg <= sbus.set_m;
          ld_s_reg <= sbus.set_s;
        end
        if (en) presc_reg <= presc_max ? '0 : presc_reg + DIV_W'(1);
        if (advance) begin
          h1_reg <= inc_h1;
          h0_reg <= inc_h0;
          m1_reg <= inc_m1;
          m0_reg <= inc_m0;
          s1_reg <= inc_s1;
          s0_reg <= inc_s0;
        end
      end
    end
  end

`ifdef TOD_ALARM_EN
  logic [5:0] alm_h_reg;
  logic [6:0] alm_m_reg;
  logic       alm_hit_reg;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      alm_h_reg   <= '0;
      alm_m_reg   <= '0;
      alm_hit_reg <= 1'b0;
    end else begin
      if (alm_we && hour_ok(alm_h) && min_sec_ok(alm_m)) begin
        alm_h_reg <= alm_h;
        alm_m_reg <= alm_m;
      end
      alm_hit_reg <= advance && ({inc_h1, inc_h0} == alm_h_reg) &&
                     ({inc_m1, inc_m0} == alm_m_reg) && ({inc_s1, inc_s0} == 7'd0);
    end
  end

  assign alm_hit = alm_hit_reg;
`endif

  assign sec_tick = sec_tick_reg;
  assign roll     = roll_reg;
  assign qm1      = m1_reg;
  assign qm0      = m0_reg;
  assign qs1      = s1_reg;
  assign qs0      = s0_reg;

  // Hours are stored 24-hour; the 12-hour view is derived here only.
  always_comb begin
    hour_bin = {3'b000, h1_reg} * 5'd10 + {1'b0, h0_reg};
    hour_12  = hour_bin;
    qpm      = 1'b0;
    qh1      = h1_reg;
    qh0      = h0_reg;
    if (!mode24) begin
      qpm = (hour_bin >= 5'd12);
      if (hour_bin == 5'd0)       hour_12 = 5'd12;
      else if (hour_bin > 5'd12)  hour_12 = hour_bin - 5'd12;
      if (hour_12 >= 5'd10) begin
        qh1 = 2'd1;
        qh0 = 4'(hour_12 - 5'd10);
      end else begin
        qh1 = 2'd0;
        qh0 = hour_12[3:0];
      end
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Bench for time_of_day_counter (DIV=4): vector table, directed corner sequences
// and a randomized run against a seconds-of-day reference model.
module tb_time_of_day_counter;
  localparam int DIV   = 4;
  localparam int DIV_W = 3;
`ifdef TOD_ALARM_EN
  localparam bit ALARM = 1'b1;
`else
  localparam bit ALARM = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       en = 1'b0;
  logic       mode24 = 1'b1;
  logic       alm_we = 1'b0;
  logic [5:0] alm_h = '0;
  logic [6:0] alm_m = '0;
  logic [1:0] qh1;
  logic [3:0] qh0, qm0, qs0;
  logic [2:0] qm1, qs1;
  logic       qpm, sec_tick, roll, dut_hit;
  logic [20:0] dut_disp;
  logic [4:0]  dut_flags;

  time_of_day_counter_if sif();

  time_of_day_counter #(.DIV(DIV), .DIV_W(DIV_W)) dut (
    .clk(clk), .clr(clr), .en(en), .mode24(mode24), .sbus(sif),
`ifdef TOD_ALARM_EN
    .alm_we(alm_we), .alm_h(alm_h), .alm_m(alm_m), .alm_hit(dut_hit),
`endif
    .qh1(qh1), .qh0(qh0), .qm1(qm1), .qm0(qm0), .qs1(qs1), .qs0(qs0),
    .qpm(qpm), .sec_tick(sec_tick), .roll(roll)
  );

`ifndef TOD_ALARM_EN
  assign dut_hit = 1'b0;
`endif
  assign dut_disp  = {qh1, qh0, qm1, qm0, qs1, qs0, qpm};
  assign dut_flags = {sif.set_ready, sif.set_err, sec_tick, roll, dut_hit};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds of day, prescaler as a plain count.
  int m_sod, m_cnt, m_pend_sod, m_alarm_min;
  bit m_pend, m_tick, m_roll, m_err, m_hit;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b, input int max);
    return (b[3:0] <= 4'd9) && (bcd2int(b) <= max);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [20:0] disp_of(input int sod, input bit m24);
    int h, mi, s, dh;
    bit pm;
    h  = sod / 3600;
    mi = (sod / 60) % 60;
    s  = sod % 60;
    if (m24) begin
      dh = h; pm = 1'b0;
    end else begin
      pm = (h >= 12);
      dh = h % 12;
      if (dh == 0) dh = 12;
    end
    return {2'(dh / 10), 4'(dh % 10), 3'(mi / 10), 4'(mi % 10), 3'(s / 10), 4'(s % 10), pm};
  endfunction

  task automatic model_reset();
    m_sod = 0; m_cnt = 0; m_pend = 0; m_pend_sod = 0; m_alarm_min = 0;
    m_tick = 0; m_roll = 0; m_err = 0; m_hit = 0;
  endtask

  task automatic model_step();
    bit legal;
    m_tick = 0; m_roll = 0; m_err = 0; m_hit = 0;
    legal = bcd_ok({2'b0, sif.set_h}, 23) && bcd_ok({1'b0, sif.set_m}, 59) &&
            bcd_ok({1'b0, sif.set_s}, 59);
    if (m_pend) begin
      m_sod = m_pend_sod; m_cnt = 0; m_pend = 0;
    end else if (sif.set_valid && legal) begin
      m_pend = 1;
      m_pend_sod = bcd2int({2'b0, sif.set_h}) * 3600 + bcd2int({1'b0, sif.set_m}) * 60 +
                   bcd2int({1'b0, sif.set_s});
    end else begin
      m_err = sif.set_valid;
      if (en) begin
        if (m_cnt == DIV - 1) begin
          m_cnt  = 0;
          m_sod  = (m_sod + 1) % 86400;
          m_tick = 1;
          m_roll = (m_sod == 0);
          m_hit  = ALARM && (m_sod == m_alarm_min * 60);
        end else begin
          m_cnt++;
        end
      end
    end
    if (alm_we && bcd_ok({2'b0, alm_h}, 23) && bcd_ok({1'b0, alm_m}, 59))
      m_alarm_min = bcd2int({2'b0, alm_h}) * 60 + bcd2int({1'b0, alm_m});
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_disp"}, 32'(dut_disp), 32'(disp_of(m_sod, mode24)));
    chk({tag, "_flags"}, 32'(dut_flags), 32'({!m_pend, m_err, m_tick, m_roll, m_hit}));
  endtask

  // One clock: edge, model update with the inputs seen at the edge, compare, back to negedge.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    compare_all(tag);
    @(negedge clk);
  endtask

  task automatic do_load(input logic [5:0] h, input logic [6:0] m, input logic [6:0] s);
    sif.set_valid = 1'b1; sif.set_h = h; sif.set_m = m; sif.set_s = s;
    cycle("load_req");
    sif.set_valid = 1'b0; sif.set_h = 6'h3F; sif.set_m = 7'h7F; sif.set_s = 7'h7F;
    cycle("load_do");
  endtask

  typedef struct {
    logic [5:0] h;
    logic [6:0] m;
    logic [6:0] s;
    bit         legal;
    logic [5:0] h12;
    bit         pm;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [5:0] last_h, last_h12, rh;
    logic [6:0] last_m, last_s, rm, rs;
    bit         last_pm;
    int         ticks, rolls, hits, n, first_roll, second_roll;
    int         tick_at[$];
    int         hi, mi, si, r;

    vecs[0]  = '{6'h13, 7'h05, 7'h00, 1'b1, 6'h01, 1'b1};
    vecs[1]  = '{6'h00, 7'h30, 7'h15, 1'b1, 6'h12, 1'b0};
    vecs[2]  = '{6'h12, 7'h00, 7'h00, 1'b1, 6'h12, 1'b1};
    vecs[3]  = '{6'h11, 7'h59, 7'h59, 1'b1, 6'h11, 1'b0};
    vecs[4]  = '{6'h24, 7'h00, 7'h00, 1'b0, 6'h00, 1'b0};
    vecs[5]  = '{6'h10, 7'h60, 7'h00, 1'b0, 6'h00, 1'b0};
    vecs[6]  = '{6'h23, 7'h59, 7'h58, 1'b1, 6'h11, 1'b1};
    vecs[7]  = '{6'h10, 7'h00, 7'h5A, 1'b0, 6'h00, 1'b0};
    vecs[8]  = '{6'h1A, 7'h00, 7'h00, 1'b0, 6'h00, 1'b0};
    vecs[9]  = '{6'h20, 7'h45, 7'h30, 1'b1, 6'h08, 1'b1};
    vecs[10] = '{6'h09, 7'h07, 7'h03, 1'b1, 6'h09, 1'b0};

    sif.set_valid = 1'b0; sif.set_h = '0; sif.set_m = '0; sif.set_s = '0;
    model_reset();

    // Reset state in both display modes
    #2 clr = 1'b0;
    #1 compare_all("reset");
    chk("reset_24h", 32'(dut_disp), 32'(21'd0));
    mode24 = 1'b0;
    #1 chk("reset_12h", 32'(dut_disp), 32'({6'h12, 7'h00, 7'h00, 1'b0}));
    mode24 = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    $display("reset released at %0t", $time);

    // Free-run from reset: a tick every DIV cycles
    en = 1'b1;
    ticks = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle("run12");
      if (sec_tick) tick_at.push_back(i);
    end
    chk("run12_ticks", 32'(tick_at.size()), 32'd3);
    for (int i = 0; i < tick_at.size() && i < 3; i++)
      chk("run12_tick_pos", 32'(tick_at[i]), 32'(4 * (i + 1)));
    chk("run12_qs0", 32'(qs0), 32'd3);
    $display("run12: %0d ticks, qs0=%0d", tick_at.size(), qs0);

    // Load vector table with counting frozen
    en = 1'b0;
    last_h = 6'h00; last_m = 7'h00; last_s = 7'h03; last_h12 = 6'h12; last_pm = 1'b0;
    foreach (vecs[i]) begin
      sif.set_valid = 1'b1; sif.set_h = vecs[i].h; sif.set_m = vecs[i].m; sif.set_s = vecs[i].s;
      cycle("vec_req");
      chk("vec_err", 32'(sif.set_err), 32'(!vecs[i].legal));
      chk("vec_ready", 32'(sif.set_ready), 32'(!vecs[i].legal));
      sif.set_valid = 1'b0; sif.set_h = 6'h3F; sif.set_m = 7'h7F; sif.set_s = 7'h7F;
      cycle("vec_next");
      chk("vec_err_clear", 32'(sif.set_err), 32'd0);
      if (vecs[i].legal) begin
        last_h = vecs[i].h; last_m = vecs[i].m; last_s = vecs[i].s;
        last_h12 = vecs[i].h12; last_pm = vecs[i].pm;
      end
      chk("vec_24h", 32'(dut_disp), 32'({last_h, last_m, last_s, 1'b0}));
      mode24 = 1'b0;
      #1 chk("vec_12h", 32'(dut_disp), 32'({last_h12, last_m, last_s, last_pm}));
      mode24 = 1'b1;
      $display("vec %0d: set %h:%h:%h legal=%0d -> %h:%h:%h", i, vecs[i].h, vecs[i].m,
               vecs[i].s, vecs[i].legal, qh1 * 16 + qh0, qm1 * 16 + qm0, qs1 * 16 + qs0);
    end

    // Midnight wrap: ROLL only with the second tick
    do_load(6'h23, 7'h59, 7'h58);
    en = 1'b1;
    ticks = 0; rolls = 0; first_roll = -1; second_roll = -1;
    for (int k = 0; k < 20 && ticks < 2; k++) begin
      cycle("wrap");
      if (roll) rolls++;
      if (sec_tick) begin
        ticks++;
        if (ticks == 1) first_roll = int'(roll);
        else            second_roll = int'(roll);
      end
    end
    chk("wrap_ticks", 32'(ticks), 32'd2);
    chk("wrap_roll_first", 32'(first_roll), 32'd0);
    chk("wrap_roll_second", 32'(second_roll), 32'd1);
    chk("wrap_time", 32'(dut_disp), 32'd0);
    cycle("wrap_after");
    chk("wrap_roll_once", 32'(rolls + int'(roll)), 32'd1);
    $display("wrap: ticks=%0d rolls=%0d", ticks, rolls);

    // Async reset while a load is in flight aborts it
    for (int k = 0; k < 6; k++) cycle("pre_abort");
    sif.set_valid = 1'b1; sif.set_h = 6'h15; sif.set_m = 7'h20; sif.set_s = 7'h10;
    cycle("abort_req");
    sif.set_valid = 1'b0;
    #2 clr = 1'b0;
    #1 model_reset();
    compare_all("async_clr");
    chk("async_clr_ready", 32'(sif.set_ready), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    for (int k = 0; k < 3; k++) cycle("post_abort");
    chk("abort_time", 32'(dut_disp), 32'd0);
    $display("abort: time after reset %0h", dut_disp);

    // Load accepted on the edge where the prescaler is at DIV-1
    sif.set_valid = 1'b1; sif.set_h = 6'h07; sif.set_m = 7'h30; sif.set_s = 7'h45;
    cycle("edge_req");
    chk("edge_no_tick", 32'(sec_tick), 32'd0);
    sif.set_valid = 1'b0;
    cycle("edge_load");
    chk("edge_loaded", 32'(dut_disp), 32'({6'h07, 7'h30, 7'h45, 1'b0}));
    chk("edge_load_no_tick", 32'(sec_tick), 32'd0);
    n = 0;
    do begin
      cycle("edge_wait");
      n++;
    end while (!sec_tick && n < 10);
    chk("edge_tick_delay", 32'(n), 32'd4);
    $display("edge load: first tick %0d cycles after load", n);

`ifdef TOD_ALARM_EN
    // Alarm 00:01; an illegal alarm write afterwards must be ignored
    alm_we = 1'b1; alm_h = 6'h00; alm_m = 7'h01;
    cycle("alm_wr");
    alm_m = 7'h61;
    cycle("alm_wr_bad");
    alm_we = 1'b0;
    en = 1'b0;
    do_load(6'h00, 7'h00, 7'h58);
    en = 1'b1;
    hits = 0;
    for (int k = 0; k < 16; k++) begin
      cycle("alm_run");
      if (dut_hit) begin
        hits++;
        chk("alm_hit_time", 32'(dut_disp), 32'({6'h00, 7'h01, 7'h00, 1'b0}));
      end
    end
    chk("alm_hits", 32'(hits), 32'd1);
    $display("alarm: %0d hits", hits);
`endif

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      mode24 = 1'($urandom_range(0, 1));
      sif.set_valid = 1'b0;
      sif.set_h = 6'($urandom); sif.set_m = 7'($urandom); sif.set_s = 7'($urandom);
      alm_we = ($urandom_range(0, 19) == 0);
      alm_h = 6'($urandom); alm_m = 7'($urandom);
      r = $urandom_range(0, 29);
      if (r == 0) begin
        if ($urandom_range(0, 1) == 1) begin
          hi = 23; mi = 59; si = $urandom_range(50, 59);
        end else begin
          hi = $urandom_range(0, 23); mi = $urandom_range(0, 59); si = $urandom_range(50, 59);
        end
        sif.set_valid = 1'b1;
        sif.set_h = 6'(to_bcd(hi)); sif.set_m = 7'(to_bcd(mi)); sif.set_s = 7'(to_bcd(si));
        alm_h = 6'(to_bcd(hi)); alm_m = 7'(to_bcd((mi + 1) % 60));
        $display("rand %0d: load %02d:%02d:%02d", i, hi, mi, si);
      end else if (r == 1) begin
        rh = 6'($urandom); rm = 7'($urandom); rs = 7'($urandom);
        if (bcd_ok({2'b0, rh}, 23) && bcd_ok({1'b0, rm}, 59) && bcd_ok({1'b0, rs}, 59))
          rm = 7'h6A;
        sif.set_valid = 1'b1; sif.set_h = rh; sif.set_m = rm; sif.set_s = rs;
        en = 1'b0;
        $display("rand %0d: illegal request %h:%h:%h", i, rh, rm, rs);
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
